// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: word handshake, frame configuration and serial outputs of the UART transmitter
interface uart_tx_cfg_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
);
  logic [WIDTH-1:0]     i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic [DIV_WIDTH-1:0] i_div;
  logic [1:0]           i_parity;
  logic                 i_stop2;
  logic                 o_tx;
  logic                 o_busy;
  modport master (
    output i_data, i_valid, i_div, i_parity, i_stop2,
    input  o_ready, o_tx, o_busy
  );
  modport slave (
    input  i_data, i_valid, i_div, i_parity, i_stop2,
    output o_ready, o_tx, o_busy
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with zero-gap valid/ready streaming
module uart_tx_cfg #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input logic          clk,
  input logic          i_reset,
  uart_tx_cfg_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n, div_q, div_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [WIDTH-1:0]     sh, sh_n;
  logic                 par_en, par_en_n, par_bit, par_bit_n, stop2, stop2_n, tx, tx_n;
  logic                 last, accept;
  assign last        = cnt == div_q - DIV_WIDTH'(1);
  assign bus.o_ready = (state == IDLE) || (state == STOP && last && bit_cnt == BW'(stop2));
  assign accept      = bus.i_valid && bus.o_ready;
  assign bus.o_busy  = state != IDLE;
  assign bus.o_tx    = tx;
  // next-state, counters, captured frame configuration and the registered line value
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = START;
      START:   if (last) state_n = DATA;
      DATA:    if (last && bit_cnt == BW'(WIDTH - 1)) state_n = par_en ? PARITY : STOP;
      PARITY:  if (last) state_n = STOP;
      STOP:    if (bus.o_ready) state_n = accept ? START : IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n     = (accept || state == IDLE || last) ? '0 : cnt + DIV_WIDTH'(1);
    bit_n     = (state_n != state) ? '0
              : (last && (state == DATA || state == STOP)) ? bit_cnt + BW'(1) : bit_cnt;
    div_n     = accept ? ((bus.i_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : bus.i_div) : div_q;
    par_en_n  = accept ? ^bus.i_parity : par_en;
    par_bit_n = accept ? (^bus.i_data ^ bus.i_parity[1]) : par_bit;
    stop2_n   = accept ? bus.i_stop2 : stop2;
    sh_n      = accept ? bus.i_data : (state == DATA && last) ? sh >> 1 : sh;
    tx_n      = (state_n == START) ? 1'b0
              : (state_n == DATA) ? sh_n[0]
              : (state_n == PARITY) ? par_bit_n : 1'b1;
  end
  // state register; reset aborts any frame and forces the line high
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      div_q   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      div_q   <= div_n;
      par_en  <= par_en_n;
      par_bit <= par_bit_n;
      stop2   <= stop2_n;
      tx      <= tx_n;
    end
  end
endmodule
